// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one multi-cycle ALU between two requesters.
// Latency: response strobe in the 3rd cycle after the transfer edge, +1 cycle if the ALU valid is stale at issue.
// Backpressure: RDY only in IDLE and only to the granted requester; busy-time requests are held off, responses cannot stall.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   REQn_VLD/REQn_A/REQn_B/REQn_FUN  request n (n = 0,1); REQn_RDY is the combinational accept
//   RSPn_VLD                      one-cycle response strobe to requester n
//   RSP_DATA, RSP_ERR             shared result and timeout-abort flag
//   ALU_EN, ALU_A, ALU_B, ALU_FUN enable and latched operation toward the ALU
//   ALU_OUT, ALU_OUT_VALID        ALU result and valid
//   BUSY                          high whenever the FSM is not in IDLE
// Optional feature: define ALU_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
module alu_arbiter #(
  parameter int FUN_BITS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0_VLD,
  input  logic [DATA_WIDTH-1:0]   REQ0_A,
  input  logic [DATA_WIDTH-1:0]   REQ0_B,
  input  logic [FUN_BITS-1:0]     REQ0_FUN,
  output logic                    REQ0_RDY,
  input  logic                    REQ1_VLD,
  input  logic [DATA_WIDTH-1:0]   REQ1_A,
  input  logic [DATA_WIDTH-1:0]   REQ1_B,
  input  logic [FUN_BITS-1:0]     REQ1_FUN,
  output logic                    REQ1_RDY,
  output logic                    RSP0_VLD,
  output logic                    RSP1_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_ERR,
  output logic                    ALU_EN,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUN_BITS-1:0]     ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic                    BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   last;      // id of the requester served most recently
  logic   rsp_id;    // id of the operation in flight
  logic   grant_id;
  logic   xfer;
  logic   capture;
  logic   abort;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  // Reaching TIMEOUT-1 at the end of a WAIT cycle means TIMEOUT WAIT cycles have elapsed.
  assign to_hit = (to_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Tie goes to the requester that was not served last; a lone request always wins.
  assign grant_id = (REQ0_VLD && REQ1_VLD) ? ~last : REQ1_VLD;
  assign xfer     = (state == IDLE) && (REQ0_VLD || REQ1_VLD);
  assign REQ0_RDY = (state == IDLE) && REQ0_VLD && !grant_id;
  assign REQ1_RDY = (state == IDLE) && REQ1_VLD &&  grant_id;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    abort     = 1'b0;
    ALU_EN    = 1'b0;
    BUSY      = (state != IDLE);
    RSP0_VLD  = 1'b0;
    RSP1_VLD  = 1'b0;
    case (state)
      IDLE: if (xfer) state_nxt = ISSUE;
      ISSUE: begin
        ALU_EN = 1'b1;
        // A valid seen here is left over from an earlier op; the ALU drops it on this enable.
        if (!ALU_OUT_VALID) state_nxt = WAIT;
      end
      WAIT: begin
        if (ALU_OUT_VALID) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (to_hit) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP: begin
        RSP0_VLD  = !rsp_id;
        RSP1_VLD  =  rsp_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last     <= 1'b1;
      rsp_id   <= 1'b0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      RSP_DATA <= '0;
    end else begin
      if (xfer) begin
        ALU_A   <= grant_id ? REQ1_A   : REQ0_A;
        ALU_B   <= grant_id ? REQ1_B   : REQ0_B;
        ALU_FUN <= grant_id ? REQ1_FUN : REQ0_FUN;
        rsp_id  <= grant_id;
        last    <= grant_id;
      end
      if (capture)    RSP_DATA <= ALU_OUT;
      else if (abort) RSP_DATA <= '0;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_cnt  <= '0;
      RSP_ERR <= 1'b0;
    end else begin
      if (state == ISSUE && !ALU_OUT_VALID) to_cnt <= '0;
      else if (state == WAIT)               to_cnt <= to_cnt + 1'b1;
      if (capture)    RSP_ERR <= 1'b0;
      else if (abort) RSP_ERR <= 1'b1;
    end
  end
`else
  assign RSP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small behavioural ALU.
// Latency: n/a (bench).
// Backpressure: n/a (bench); every wait on the DUT is cycle-bounded.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VLD, REQ1_VLD, REQ0_RDY, REQ1_RDY;
  logic [7:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]  REQ0_FUN, REQ1_FUN;
  logic        RSP0_VLD, RSP1_VLD, RSP_ERR, ALU_EN, BUSY;
  logic [15:0] RSP_DATA;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;

  logic        alu_vld;
  logic [15:0] alu_out;
  logic        alu_hold = 1'b0;   // forces a stale valid while the ALU is not enabled
  logic        alu_dead = 1'b0;   // ALU never answers
  int          en_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 CLK = ~CLK;

  alu_arbiter dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VLD(REQ0_VLD), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN), .REQ0_RDY(REQ0_RDY),
    .REQ1_VLD(REQ1_VLD), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN), .REQ1_RDY(REQ1_RDY),
    .RSP0_VLD(RSP0_VLD), .RSP1_VLD(RSP1_VLD), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .ALU_EN(ALU_EN), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_vld), .BUSY(BUSY)
  );

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    alu_f = {8'd0, a} + {8'd0, b};
      4'd1:    alu_f = {8'd0, a} - {8'd0, b};
      4'd2:    alu_f = {8'd0, a} * {8'd0, b};
      default: alu_f = {8'd0, a & b};
    endcase
  endfunction

  // ALU: answers one cycle after an enable; an enable seen with valid high just clears it.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_vld <= 1'b0;
      alu_out <= 16'd0;
    end else if (alu_dead) begin
      alu_vld <= 1'b0;
    end else if (ALU_EN) begin
      alu_vld <= ~alu_vld;
      alu_out <= alu_f(ALU_A, ALU_B, ALU_FUN);
    end else begin
      alu_vld <= alu_hold;
    end
  end

  always @(posedge CLK) if (ALU_EN === 1'b1) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one request, expect it accepted, then drop it and scramble its fields.
  task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    @(negedge CLK);
    if (id) begin REQ1_VLD = 1'b1; REQ1_A = a; REQ1_B = b; REQ1_FUN = f; end
    else    begin REQ0_VLD = 1'b1; REQ0_A = a; REQ0_B = b; REQ0_FUN = f; end
    #1 chk("send_rdy", id ? REQ1_RDY : REQ0_RDY, 1);
    @(posedge CLK);
    #1;
    REQ0_VLD = 1'b0; REQ1_VLD = 1'b0;
    REQ0_A = 8'hFF; REQ0_B = 8'hEE; REQ0_FUN = 4'hF;
    REQ1_A = 8'hDD; REQ1_B = 8'hCC; REQ1_FUN = 4'hE;
  endtask

  // Count cycles after the transfer edge until a response strobe; lat = 0 if none within bound.
  task automatic wait_rsp(input int bound, output int lat, output int id,
                          output logic [15:0] d, output logic e);
    lat = 0; id = -1; d = 16'hxxxx; e = 1'bx;
    for (int c = 1; c <= bound; c++) begin
      @(negedge CLK);
      if (RSP0_VLD || RSP1_VLD) begin
        lat = c; id = RSP1_VLD ? 1 : 0; d = RSP_DATA; e = RSP_ERR;
        break;
      end
    end
  endtask

  int          lat, id, got, strobes, en0;
  logic [15:0] d;
  logic        e;
  int          ids [4];
  logic [15:0] dat [4];

  initial begin
    RST = 1'b1;
    REQ0_VLD = 1'b1; REQ0_A = 8'd1;  REQ0_B = 8'd1;  REQ0_FUN = 4'd0;
    REQ1_VLD = 1'b1; REQ1_A = 8'd10; REQ1_B = 8'd20; REQ1_FUN = 4'd0;
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);

    // reset state
    chk("rst_busy", BUSY, 0);
    chk("rst_alu_en", ALU_EN, 0);
    chk("rst_rsp_vld", {RSP0_VLD, RSP1_VLD}, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_rsp_err", RSP_ERR, 0);
    chk("rst_alu_op", {ALU_A, ALU_B, ALU_FUN}, 0);

    // tie from reset: requester 0 first, then alternate
    RST = 1'b1;
    #1 chk("tie_rdy0", REQ0_RDY, 1);
    chk("tie_rdy1", REQ1_RDY, 0);
    got = 0;
    for (int c = 0; c < 200 && got < 4; c++) begin
      @(negedge CLK);
      if (RSP0_VLD || RSP1_VLD) begin
        ids[got] = RSP1_VLD ? 1 : 0;
        dat[got] = RSP_DATA;
        got++;
        if (got == 4) begin REQ0_VLD = 1'b0; REQ1_VLD = 1'b0; end
      end
    end
    chk("tie_count", got, 4);
    for (int i = 0; i < got; i++) begin
      chk("tie_id", ids[i], (i % 2));
      chk("tie_data", dat[i], (i % 2) ? 30 : 2);
    end
    @(negedge CLK);

    // single request 5 + 3
    en0 = en_cnt;
    send(0, 8'd5, 8'd3, 4'd0);
    chk("single_alu_a", ALU_A, 5);
    chk("single_alu_b", ALU_B, 3);
    chk("single_alu_fun", ALU_FUN, 0);
    wait_rsp(20, lat, id, d, e);
    chk("single_lat", lat, 3);
    chk("single_id", id, 0);
    chk("single_data", d, 8);
    chk("single_err", e, 0);
    chk("single_en_cycles", en_cnt - en0, 1);
    @(negedge CLK);
    chk("single_strobe_1cyc", {RSP0_VLD, RSP1_VLD}, 0);
    chk("single_data_hold", RSP_DATA, 8);
    chk("single_idle", BUSY, 0);

    // valid withdrawn before the edge: nothing happens
    @(negedge CLK);
    REQ1_VLD = 1'b1; REQ1_A = 8'd77;
    #1 chk("drop_rdy1", REQ1_RDY, 1);
    #2 REQ1_VLD = 1'b0;
    @(negedge CLK);
    chk("drop_busy", BUSY, 0);
    chk("drop_alu_a", ALU_A, 5);

    // stale ALU valid at issue: 4 * 4 via requester 1
    alu_hold = 1'b1;
    repeat (2) @(negedge CLK);
    en0 = en_cnt;
    send(1, 8'd4, 8'd4, 4'd2);
    alu_hold = 1'b0;
    wait_rsp(20, lat, id, d, e);
    chk("stale_lat", lat, 4);
    chk("stale_id", id, 1);
    chk("stale_data", d, 16);
    chk("stale_en_cycles", en_cnt - en0, 2);

    // reset while waiting on a silent ALU
    alu_dead = 1'b1;
    send(0, 8'd9, 8'd9, 4'd0);
    repeat (3) @(negedge CLK);
    chk("wait_busy", BUSY, 1);
    chk("wait_alu_en", ALU_EN, 0);
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_ctl", {ALU_EN, RSP0_VLD, RSP1_VLD, RSP_ERR}, 0);
    chk("mid_rst_data", RSP_DATA, 0);
    chk("mid_rst_alu_op", {ALU_A, ALU_B, ALU_FUN}, 0);
    strobes = 0;
    repeat (2) begin @(negedge CLK); if (RSP0_VLD || RSP1_VLD) strobes++; end
    RST = 1'b1;
    alu_dead = 1'b0;
    repeat (4) begin @(negedge CLK); if (RSP0_VLD || RSP1_VLD) strobes++; end
    chk("mid_rst_no_rsp", strobes, 0);
    send(1, 8'd6, 8'd7, 4'd2);
    wait_rsp(20, lat, id, d, e);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_id", id, 1);
    chk("post_rst_data", d, 42);
    chk("post_rst_err", e, 0);

    // ALU never answers
    alu_dead = 1'b1;
    send(0, 8'd1, 8'd2, 4'd0);
    wait_rsp(40, lat, id, d, e);
`ifdef ALU_ARB_TIMEOUT_EN
    chk("timeout_lat", lat, 17);
    chk("timeout_id", id, 0);
    chk("timeout_data", d, 0);
    chk("timeout_err", e, 1);
`else
    chk("hang_no_rsp", lat, 0);
    chk("hang_busy", BUSY, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FUN_BITS, 4, ALU function code width.
REQ-002 Parameter: DATA_WIDTH, 8, operand width; result width is 2*DATA_WIDTH.
REQ-003 Parameter: TIMEOUT, 15, maximum WAIT cycles before abort (used only with ALU_ARB_TIMEOUT_EN).
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-low.
REQ-006 REQ0_VLD, REQ1_VLD  input  1 each  requester n has an operation pending.
REQ-007 REQ0_A/REQ0_B, REQ1_A/REQ1_B  input  DATA_WIDTH each  operands.
REQ-008 REQ0_FUN, REQ1_FUN  input  FUN_BITS each  ALU function code.
REQ-009 REQ0_RDY, REQ1_RDY  output  1 each  combinational accept; a transfer occurs on an edge where VLD and RDY are both 1.
REQ-010 RSP0_VLD, RSP1_VLD  output  1 each  one-cycle response strobe.
REQ-011 RSP_DATA  output  2*DATA_WIDTH  result, shared by both requesters.
REQ-012 RSP_ERR  output  1  response is a timeout abort.
REQ-013 ALU_EN  output  1  ALU enable.
REQ-014 ALU_A, ALU_B  output  DATA_WIDTH; ALU_FUN  output  FUN_BITS  latched operands and function.
REQ-015 ALU_OUT  input  2*DATA_WIDTH; ALU_OUT_VALID  input  1  ALU result and valid.
REQ-016 BUSY  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: RDY is asserted only to the granted requester. If exactly one VLD is high, that requester is granted. If both are high, the requester other than the last-served pointer LAST is granted.
REQ-019 On a transfer edge: latch A, B and FUN into ALU_A/ALU_B/ALU_FUN; record the granted id; set LAST to that id; go to ISSUE.
REQ-020 A VLD that drops before a transfer edge causes no transfer and no state change.
REQ-021 ISSUE: ALU_EN=1.
  - If ALU_OUT_VALID=1 (stale), stay in ISSUE; the ALU clears its valid on this Enable.
  - If ALU_OUT_VALID=0, go to WAIT.
REQ-022 WAIT: ALU_EN=0. On ALU_OUT_VALID=1, register ALU_OUT into RSP_DATA and go to RESP.
REQ-023 RESP: assert RSPn_VLD of the recorded id for exactly one cycle, with RSP_DATA and RSP_ERR stable; go to IDLE. There is no response backpressure.
REQ-024 Latency: RSPn_VLD is high in the 3rd cycle after the transfer edge; add 1 cycle if the ALU valid was stale at ISSUE.
REQ-025 RDY is 0 in all states other than IDLE; requests arriving while BUSY are held off, not queued.
REQ-026 RSP_DATA holds its value until the next capture; ALU_A/ALU_B/ALU_FUN hold until the next transfer.
REQ-027 The operation is issued with the latched fields only; changes on the REQ inputs after the transfer are ignored.

Reset
REQ-028 RST low asynchronously forces:
  - state IDLE, LAST=1 (requester 0 wins the first tie);
  - ALU_EN, RSP0_VLD, RSP1_VLD, RSP_ERR, BUSY = 0;
  - RSP_DATA, ALU_A, ALU_B, ALU_FUN = 0; timeout counter = 0.
REQ-029 Reset mid-operation abandons the operation; no response is produced for it.

Configuration
REQ-030 Macro ALU_ARB_TIMEOUT_EN defined:
  - a counter clears on entry to WAIT and increments each WAIT cycle;
  - if it reaches TIMEOUT without ALU_OUT_VALID, go to RESP with RSP_DATA=0 and RSP_ERR=1;
  - a normal capture drives RSP_ERR=0.
REQ-031 Macro ALU_ARB_TIMEOUT_EN undefined: no counter is present, WAIT waits indefinitely, and RSP_ERR is tied 0.

Verification
REQ-032 Single request: REQ0 A=8'd5, B=8'd3, FUN=4'b0000; ALU model returns valid one cycle after Enable -> RSP0_VLD in the 3rd cycle after the transfer, RSP_DATA=16'd8, RSP_ERR=0.
REQ-033 Tie: both VLD high from reset -> REQ0 served first, then REQ1. Hold both VLD high for 4 operations -> grants alternate 0,1,0,1.
REQ-034 Stale valid: ALU_OUT_VALID held at 1 at ISSUE entry -> ALU_EN high for 2 cycles; response is 1 cycle later than in REQ-032.
REQ-035 Reset asserted in WAIT -> all outputs are 0 immediately, with no RSP strobe. After release, REQ1 only, A=8'd6, B=8'd7, FUN=4'b0010 -> RSP1_VLD, RSP_DATA=16'd42.
REQ-036 With ALU_ARB_TIMEOUT_EN, TIMEOUT=15, and the ALU never asserting valid -> RSP0_VLD with RSP_ERR=1 and RSP_DATA=0 after 15 WAIT cycles. Without the macro, BUSY stays 1 and no response is produced.
